insn_buffer_nway: RTL and testbench
===================================

Name: insn_buffer_nway

Overview:
N-wide circular instruction FIFO between fetch and dispatch, for the superscalar front end. It accepts up to WIDTH instruction packets per cycle and presents up to WIDTH oldest packets to dispatch. Dispatch retires a variable count per cycle. A single-cycle squash flushes the whole buffer on branch mispredict or exception.

Parameters:
DEPTH, 16, number of entries; power of 2, must be >= 2*WIDTH
WIDTH, 2, enqueue/dequeue lanes per cycle; >= 1
PKT_W, 96, bits per instruction packet (opaque payload; valid travels separately)

Ports:
clock  in  1  clock, all state updates on posedge
reset  in  1  synchronous, active-high; highest priority
squash_in  in  1  synchronous flush
enq_valid  in  WIDTH  per-lane packet valid from fetch; lane 0 is oldest
enq_pkt  in  WIDTH*PKT_W  lane i packet at bits [i*PKT_W +: PKT_W]
enq_accept  out  WIDTH  per-lane accept mask, combinational
deq_valid  out  WIDTH  lane i holds a valid packet (lane 0 = oldest)
deq_pkt  out  WIDTH*PKT_W  oldest WIDTH entries starting at head
deq_count  in  $clog2(WIDTH)+1  packets consumed by dispatch this cycle
count  out  $clog2(DEPTH)+1  occupied entries, registered
free_slots  out  $clog2(DEPTH)+1  DEPTH - count
ib_empty  out  1  count == 0
ib_full  out  1  count == DEPTH
almost_full  out  1  free_slots < WIDTH; fetch stalls on this

Behaviour:
- State: DEPTH x PKT_W storage, head/tail pointers of $clog2(DEPTH) bits, count register. Pointers wrap modulo DEPTH naturally.
- Reset or squash_in: head = tail = count = 0 next cycle. All enq/deq activity in that cycle is ignored. Storage contents are don't-care.
- After reset: deq_valid = 0, count = 0, free_slots = DEPTH, ib_empty = 1, ib_full = 0, almost_full = 0.
- Enqueue acceptance:
  - Lanes are taken in order from lane 0. n_lead = number of leading consecutive valid lanes; a valid lane after an invalid lane is never accepted.
  - n_acc = min(n_lead, free_slots), computed from the registered count. Space freed by this cycle's dequeue is not counted.
  - enq_accept[i] = 1 for i < n_acc. Accepted lane i is written to entry (tail + i) mod DEPTH; tail advances by n_acc.
  - enq_accept is forced to 0 while reset or squash_in is high.
- Dequeue presentation:
  - deq_valid[i] = (count > i). deq_pkt lane i = entry (head + i) mod DEPTH. Outputs are derived from registered state only.
  - No bypass: a packet enqueued in cycle t is first visible on deq in cycle t+1, so minimum latency is 1 cycle.
- Dequeue consumption:
  - n_deq = min(deq_count, count, WIDTH); head advances by n_deq.
  - deq_count > count is a protocol violation: it is clamped and flagged by a simulation-only assertion.
- Count update: count_next = count + n_acc - n_deq. Simultaneous enqueue and dequeue in one cycle is legal and both take effect.
- Full: n_acc = 0 and all enq_accept = 0. Dequeue in the same cycle still proceeds, and the next cycle may accept.
- Empty: deq_valid = 0 and any deq_count is clamped to 0.
- Wrap-around: a multi-lane enqueue or dequeue crossing the DEPTH-1 -> 0 boundary splits correctly.
- No combinational path from deq_count to enq_accept.

Test Plan:
- Reset, then enqueue A,B in one cycle with deq_count = 0 -> next cycle count = 2, deq_valid = 2'b11, deq_pkt lanes = {B, A}, enq_accept was 2'b11.
- Fill DEPTH = 16 with 8 two-lane enqueues -> ib_full = 1, almost_full = 1; the next enqueue of 2 gives enq_accept = 00 and count stays 16. With count = 15 and 2 offered -> enq_accept = 01, count = 16.
- enq_valid = 2'b10 (gap at lane 0) -> enq_accept = 00, count unchanged.
- count = 1 holding X; same cycle enqueue Y,Z and deq_count = 1 -> next cycle count = 2, deq lane0 = Y, lane1 = Z.
- Advance head and tail to 15, enqueue P,Q -> P in entry 15, Q in entry 0; next cycle deq lanes = {Q, P}, and deq_count = 2 makes head = 1.
- count = 10 with squash_in = 1 alongside enq_valid = 11 and deq_count = 2 -> next cycle count = 0, ib_empty = 1, deq_valid = 00, enq_accept was 00. Repeat the same check using reset.

Source files
------------

// File: rtl/insn_buffer_nway.sv
// insn_buffer_nway: N-wide circular instruction FIFO between fetch and dispatch.
//
// Fetch offers up to WIDTH packets per cycle. Lanes are accepted in order,
// starting at lane 0, up to the free space left by the registered count.
// Dispatch sees the WIDTH oldest entries and retires a variable number of
// them each cycle. squash_in flushes the whole buffer in one cycle.
//
// Ports:
//   clock, reset      clock; synchronous active-high reset (highest priority)
//   squash_in         synchronous flush (branch mispredict / exception)
//   enq_valid/enq_pkt per-lane packets from fetch; lane 0 is the oldest
//   enq_accept        per-lane accept mask (combinational, from registered count)
//   deq_valid/deq_pkt oldest WIDTH entries, starting at head
//   deq_count         packets consumed by dispatch this cycle
//   count/free_slots  occupancy and DEPTH - occupancy (registered)
//   ib_empty/ib_full/almost_full  registered status flags

// Protocol checker: dispatch must never consume more than is held.
module insn_buffer_nway_chk #(
  parameter int NW = 5,
  parameter int CW = 2
) (
  input logic          clock,
  input logic          reset,
  input logic          squash_in,
  input logic [CW-1:0] deq_count,
  input logic [NW-1:0] count
);
  logic [NW-1:0] deq_ext_s;

  assign deq_ext_s = {{(NW-CW){1'b0}}, deq_count};

  a_deq_not_over_count: assert property (
    @(posedge clock) disable iff (reset || squash_in) deq_ext_s <= count
  );
endmodule

module insn_buffer_nway #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 2,
  parameter int PKT_W = 96
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       squash_in,
  input  logic [WIDTH-1:0]           enq_valid,
  input  logic [WIDTH*PKT_W-1:0]     enq_pkt,
  output logic [WIDTH-1:0]           enq_accept,
  output logic [WIDTH-1:0]           deq_valid,
  output logic [WIDTH*PKT_W-1:0]     deq_pkt,
  input  logic [$clog2(WIDTH):0]     deq_count,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH):0]     free_slots,
  output logic                       ib_empty,
  output logic                       ib_full,
  output logic                       almost_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [NW-1:0] DEPTH_N = NW'(DEPTH);
  localparam logic [NW-1:0] WIDTH_N = NW'(WIDTH);

  logic [PKT_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]    head_r;
  logic [AW-1:0]    tail_r;

  logic             flush_s;
  logic [NW-1:0]    n_lead_s;
  logic [NW-1:0]    free_now_s;
  logic [NW-1:0]    n_acc_s;
  logic [NW-1:0]    deq_ext_s;
  logic [NW-1:0]    n_deq_s;
  logic [NW-1:0]    count_next_s;
  logic [NW-1:0]    free_next_s;

  assign flush_s    = reset | squash_in;
  assign free_now_s = DEPTH_N - count;
  assign deq_ext_s  = {{(NW-CW){1'b0}}, deq_count};

  // Leading run of valid lanes; a valid lane after a gap is not counted.
  always_comb begin
    logic run_v;
    n_lead_s = '0;
    run_v    = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (run_v && enq_valid[i]) begin
        n_lead_s = n_lead_s + NW'(1);
      end else begin
        run_v = 1'b0;
      end
    end
  end

  // Accepted lane count: limited by space from the registered count only,
  // so deq_count has no path into enq_accept.
  always_comb begin
    if (flush_s) begin
      n_acc_s = '0;
    end else if (n_lead_s < free_now_s) begin
      n_acc_s = n_lead_s;
    end else begin
      n_acc_s = free_now_s;
    end
  end

  // Per-lane accept mask: the first n_acc lanes.
  always_comb begin
    enq_accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      enq_accept[i] = (NW'(i) < n_acc_s);
    end
  end

  // Retired count: dispatch request clamped to occupancy and lane count.
  always_comb begin
    n_deq_s = deq_ext_s;
    if (count < n_deq_s) begin
      n_deq_s = count;
    end else begin
      n_deq_s = n_deq_s;
    end
    if (WIDTH_N < n_deq_s) begin
      n_deq_s = WIDTH_N;
    end else begin
      n_deq_s = n_deq_s;
    end
  end

  assign count_next_s = count + n_acc_s - n_deq_s;
  assign free_next_s  = DEPTH_N - count_next_s;

  // Dispatch view: WIDTH entries starting at head, wrapping modulo DEPTH.
  always_comb begin
    deq_pkt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      deq_pkt[i*PKT_W +: PKT_W] = mem_r[head_r + AW'(i)];
    end
  end

  // Packet storage: accepted lane i lands at tail + i; no reset needed.
  always_ff @(posedge clock) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (!flush_s && (NW'(i) < n_acc_s)) begin
        mem_r[tail_r + AW'(i)] <= enq_pkt[i*PKT_W +: PKT_W];
      end
    end
  end

  // Pointers, occupancy and registered status flags.
  always_ff @(posedge clock) begin
    if (flush_s) begin
      head_r      <= '0;
      tail_r      <= '0;
      count       <= '0;
      free_slots  <= DEPTH_N;
      ib_empty    <= 1'b1;
      ib_full     <= 1'b0;
      almost_full <= 1'b0;
      deq_valid   <= '0;
    end else begin
      // n_acc and n_deq never exceed WIDTH < DEPTH, so the low bits suffice.
      head_r      <= head_r + n_deq_s[AW-1:0];
      tail_r      <= tail_r + n_acc_s[AW-1:0];
      count       <= count_next_s;
      free_slots  <= free_next_s;
      ib_empty    <= (count_next_s == '0);
      ib_full     <= (count_next_s == DEPTH_N);
      almost_full <= (free_next_s < WIDTH_N);
      for (int i = 0; i < WIDTH; i++) begin
        deq_valid[i] <= (count_next_s > NW'(i));
      end
    end
  end

  insn_buffer_nway_chk #(
    .NW(NW),
    .CW(CW)
  ) u_chk (
    .clock     (clock),
    .reset     (reset),
    .squash_in (squash_in),
    .deq_count (deq_count),
    .count     (count)
  );
endmodule

// File: tb/tb_insn_buffer_nway.sv
// Testbench for insn_buffer_nway: a queue-based reference model checked on
// every negedge, plus directed scenarios with hand-computed literal values.
module tb_insn_buffer_nway;
  localparam int D  = 16;
  localparam int W  = 2;
  localparam int P  = 96;
  localparam int NW = 5;
  localparam int CW = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic              squash_in;
  logic [W-1:0]      enq_valid;
  logic [W*P-1:0]    enq_pkt;
  logic [W-1:0]      enq_accept;
  logic [W-1:0]      deq_valid;
  logic [W*P-1:0]    deq_pkt;
  logic [CW-1:0]     deq_count;
  logic [NW-1:0]     count;
  logic [NW-1:0]     free_slots;
  logic              ib_empty;
  logic              ib_full;
  logic              almost_full;

  always #5 clock = ~clock;

  insn_buffer_nway #(.DEPTH(D), .WIDTH(W), .PKT_W(P)) dut (
    .clock(clock), .reset(reset), .squash_in(squash_in),
    .enq_valid(enq_valid), .enq_pkt(enq_pkt), .enq_accept(enq_accept),
    .deq_valid(deq_valid), .deq_pkt(deq_pkt), .deq_count(deq_count),
    .count(count), .free_slots(free_slots), .ib_empty(ib_empty),
    .ib_full(ib_full), .almost_full(almost_full)
  );

  int            tests = 0;
  int            fails = 0;
  logic [P-1:0]  q[$];
  bit            model_ok = 1'b0;
  logic [W-1:0]  last_acc;

  function automatic logic [P-1:0] mk(input int id);
    return {32'(id) ^ 32'hA5A5_0000, 32'hC0DE_0000 + 32'(id), ~32'(id)};
  endfunction

  // Model: how many lanes the rules allow this cycle (pre-dequeue space).
  function automatic int model_acc();
    int lead = 0;
    int free = D - q.size();
    if (reset || squash_in) return 0;
    for (int i = 0; i < W; i++) begin
      if (!enq_valid[i]) break;
      lead++;
    end
    return (lead < free) ? lead : free;
  endfunction

  function automatic void model_step();
    int na;
    int nd;
    if (reset || squash_in) begin
      q.delete();
      return;
    end
    na = model_acc();
    nd = int'(deq_count);
    if (nd > q.size()) nd = q.size();
    if (nd > W) nd = W;
    for (int i = 0; i < nd; i++) void'(q.pop_front());
    for (int i = 0; i < na; i++) q.push_back(enq_pkt[i*P +: P]);
  endfunction

  task automatic chk(input string name, input logic [P-1:0] act, input logic [P-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model update on the same edge the DUT updates.
  always @(posedge clock) begin
    if (model_ok) model_step();
    else if (reset) begin
      q.delete();
      model_ok <= 1'b1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clock) begin
    if (model_ok) begin
      logic [W-1:0] am;
      logic [W-1:0] vm;
      am = '0;
      vm = '0;
      for (int i = 0; i < W; i++) begin
        am[i] = (i < model_acc());
        vm[i] = (q.size() > i);
      end
      chk("m_enq_accept", P'(enq_accept), P'(am));
      chk("m_deq_valid", P'(deq_valid), P'(vm));
      chk("m_count", P'(count), P'(q.size()));
      chk("m_free_slots", P'(free_slots), P'(D - q.size()));
      chk("m_ib_empty", P'(ib_empty), P'(q.size() == 0));
      chk("m_ib_full", P'(ib_full), P'(q.size() == D));
      chk("m_almost_full", P'(almost_full), P'((D - q.size()) < W));
      for (int i = 0; i < W; i++) begin
        if (i < q.size()) chk("m_deq_pkt", deq_pkt[i*P +: P], q[i]);
      end
    end
  end

  task automatic cyc(input logic r, input logic s, input logic [W-1:0] ev,
                     input logic [P-1:0] p0, input logic [P-1:0] p1,
                     input logic [CW-1:0] dc);
    reset     = r;
    squash_in = s;
    enq_valid = ev;
    enq_pkt   = {p1, p0};
    deq_count = dc;
    @(negedge clock);
    last_acc = enq_accept;
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset
    cyc(1'b1, 1'b0, 2'b00, '0, '0, 2'd0);
    cyc(1'b1, 1'b0, 2'b00, '0, '0, 2'd0);
    cyc(1'b0, 1'b0, 2'b00, '0, '0, 2'd0);
    chk("rst_count", P'(count), P'(5'd0));
    chk("rst_free", P'(free_slots), P'(5'd16));
    chk("rst_empty", P'(ib_empty), P'(1'b1));
    chk("rst_full", P'(ib_full), P'(1'b0));
    chk("rst_af", P'(almost_full), P'(1'b0));
    chk("rst_deq_valid", P'(deq_valid), P'(2'b00));

    // A,B in one cycle
    cyc(1'b0, 1'b0, 2'b11, mk(1), mk(2), 2'd0);
    chk("ab_acc", P'(last_acc), P'(2'b11));
    chk("ab_count", P'(count), P'(5'd2));
    chk("ab_valid", P'(deq_valid), P'(2'b11));
    chk("ab_lane0", deq_pkt[0 +: P], mk(1));
    chk("ab_lane1", deq_pkt[P +: P], mk(2));

    // Fill to DEPTH, then offer more
    for (int k = 0; k < 7; k++) cyc(1'b0, 1'b0, 2'b11, mk(10 + 2*k), mk(11 + 2*k), 2'd0);
    chk("fill_count", P'(count), P'(5'd16));
    chk("fill_full", P'(ib_full), P'(1'b1));
    chk("fill_af", P'(almost_full), P'(1'b1));
    cyc(1'b0, 1'b0, 2'b11, mk(40), mk(41), 2'd0);
    chk("full_acc", P'(last_acc), P'(2'b00));
    chk("full_count", P'(count), P'(5'd16));

    // count = 15 with two offered
    cyc(1'b0, 1'b0, 2'b00, '0, '0, 2'd1);
    chk("c15_count", P'(count), P'(5'd15));
    cyc(1'b0, 1'b0, 2'b11, mk(42), mk(43), 2'd0);
    chk("c15_acc", P'(last_acc), P'(2'b01));
    chk("c15_count2", P'(count), P'(5'd16));

    // Drain
    for (int k = 0; k < 8; k++) cyc(1'b0, 1'b0, 2'b00, '0, '0, 2'd2);
    chk("drain_empty", P'(ib_empty), P'(1'b1));

    // Gap at lane 0
    cyc(1'b0, 1'b0, 2'b10, mk(50), mk(51), 2'd0);
    chk("gap_acc", P'(last_acc), P'(2'b00));
    chk("gap_count", P'(count), P'(5'd0));

    // X held, then Y,Z in with X out
    cyc(1'b0, 1'b0, 2'b01, mk(60), '0, 2'd0);
    cyc(1'b0, 1'b0, 2'b11, mk(61), mk(62), 2'd1);
    chk("xyz_count", P'(count), P'(5'd2));
    chk("xyz_lane0", deq_pkt[0 +: P], mk(61));
    chk("xyz_lane1", deq_pkt[P +: P], mk(62));

    // Wrap: bring head and tail to 15 from a fresh reset
    cyc(1'b1, 1'b0, 2'b00, '0, '0, 2'd0);
    cyc(1'b0, 1'b0, 2'b11, mk(70), mk(71), 2'd0);
    for (int k = 0; k < 6; k++) cyc(1'b0, 1'b0, 2'b11, mk(72 + 2*k), mk(73 + 2*k), 2'd2);
    cyc(1'b0, 1'b0, 2'b01, mk(90), '0, 2'd2);
    cyc(1'b0, 1'b0, 2'b00, '0, '0, 2'd1);
    chk("wrap_pre_empty", P'(ib_empty), P'(1'b1));
    cyc(1'b0, 1'b0, 2'b11, mk(91), mk(92), 2'd0);
    chk("wrap_count", P'(count), P'(5'd2));
    chk("wrap_lane0_p", deq_pkt[0 +: P], mk(91));
    chk("wrap_lane1_q", deq_pkt[P +: P], mk(92));
    cyc(1'b0, 1'b0, 2'b00, '0, '0, 2'd2);
    chk("wrap_post_count", P'(count), P'(5'd0));
    cyc(1'b0, 1'b0, 2'b01, mk(93), '0, 2'd0);
    chk("wrap_r_lane0", deq_pkt[0 +: P], mk(93));
    cyc(1'b0, 1'b0, 2'b00, '0, '0, 2'd1);

    // Squash at count = 10
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 2'b11, mk(100 + 2*k), mk(101 + 2*k), 2'd0);
    chk("sq_pre_count", P'(count), P'(5'd10));
    cyc(1'b0, 1'b1, 2'b11, mk(120), mk(121), 2'd2);
    chk("sq_acc", P'(last_acc), P'(2'b00));
    chk("sq_count", P'(count), P'(5'd0));
    chk("sq_empty", P'(ib_empty), P'(1'b1));
    chk("sq_valid", P'(deq_valid), P'(2'b00));

    // Same with reset
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 2'b11, mk(130 + 2*k), mk(131 + 2*k), 2'd0);
    chk("rs_pre_count", P'(count), P'(5'd10));
    cyc(1'b1, 1'b0, 2'b11, mk(150), mk(151), 2'd2);
    chk("rs_acc", P'(last_acc), P'(2'b00));
    chk("rs_count", P'(count), P'(5'd0));
    chk("rs_empty", P'(ib_empty), P'(1'b1));
    chk("rs_valid", P'(deq_valid), P'(2'b00));

    cyc(1'b0, 1'b0, 2'b00, '0, '0, 2'd0);
    cyc(1'b0, 1'b0, 2'b00, '0, '0, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
